cancid_ctx_matcher: RTL and testbench
=====================================

CANCID_CTX_MATCHER -- requirements
Module: cancid_ctx_matcher

Interface
REQ-001 Parameter N_STREAMS, default 64, number of tracked stream contexts (power of 2, 2..256).
REQ-002 Parameter SID_W, default $clog2(N_STREAMS), stream-id width.
REQ-003 Parameter STATE_W, default 11, regex engine state width.
REQ-004 Parameter COUNT_W, default 16, per-stream match counter width.
REQ-005 clk  in  1  sole clock, all logic on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 sop  in  1  packet start strobe; loads the context for stream_id.
REQ-008 stream_id  in  SID_W  stream of the current packet; sampled on sop.
REQ-009 enable  in  1  regex enabled for this stream; sampled on sop.
REQ-010 char_in / char_in_vld  in  8 / 1  payload byte and qualifier.
REQ-011 eop  in  1  packet end strobe; may coincide with the last char_in_vld.
REQ-012 eng_state_in / eng_state_in_vld  out  STATE_W / 1  state load to the external regex engine.
REQ-013 eng_char / eng_char_vld  out  8 / 1  byte forwarded to the engine.
REQ-014 eng_state_out / eng_accept  in  STATE_W / 1  engine state and match flag, one cycle after each byte.
REQ-015 cnt_rd_sid  in  SID_W  counter read address.
REQ-016 cnt_rd_data  out  COUNT_W  counter of cnt_rd_sid, registered.
REQ-017 fired  out  1  match seen in the current packet.
REQ-018 busy  out  1  high in any state other than IDLE.
REQ-019 proto_err  out  1  sticky protocol-violation flag.

Function
REQ-020 FSM states IDLE, LOAD, RUN, COMMIT; sop in IDLE -> LOAD; LOAD -> RUN after 1 cycle; eop in RUN -> COMMIT; COMMIT -> IDLE after 1 cycle.
REQ-021 On sop in IDLE, latch stream_id and enable; clear fired.
REQ-022 In LOAD, drive eng_state_in_vld=1 for exactly one cycle, with eng_state_in = state_mem[sid] if ctx_valid[sid] else 0.
REQ-023 In RUN, eng_char_vld = char_in_vld and eng_char = char_in (combinational pass-through); char_in_vld outside RUN is dropped and sets proto_err.
REQ-024 eng_accept high in RUN or COMMIT sets fired to 1 until the next sop.
REQ-025 In COMMIT with latched enable=1: state_mem[sid] <= eng_state_out, ctx_valid[sid] <= 1, count[sid] <= count[sid] + fired_final, where fired_final includes an eng_accept arriving in COMMIT.
REQ-026 In COMMIT with latched enable=0: no state or counter write; fired cleared.
REQ-027 sop outside IDLE, or eop outside RUN, is ignored and sets proto_err.
REQ-028 cnt_rd_data = count[cnt_rd_sid] one cycle after address; a read coinciding with a COMMIT write to the same sid returns the pre-commit value.
REQ-029 Counter addition is modulo 2^COUNT_W unless REQ-033 applies.

Reset
REQ-030 rst_n low: FSM -> IDLE; fired, busy, proto_err, eng_*_vld, cnt_rd_data = 0; all counters = 0; all ctx_valid = 0.
REQ-031 state_mem contents are not reset; ctx_valid gating makes them unobservable.
REQ-032 Reset mid-packet aborts the packet with no commit.

Configuration
REQ-033 With CANCID_CTX_SAT_COUNT_EN defined, counters saturate at 2^COUNT_W-1; without it, they wrap to 0.

Structure
REQ-034 Shared package cancid_pkg holds the FSM state enum and defaults for STATE_W and COUNT_W.
REQ-035 Sub-module cancid_ctx_ram: N_STREAMS x STATE_W, one write port and one combinational read port, no reset.
REQ-036 Counters and ctx_valid are flops in the top module.

Verification
REQ-037 Reset, then sop sid=3 en=1, bytes, eop with no accept -> eng_state_in=0, count[3]=0, ctx_valid[3]=1.
REQ-038 Packet sid=5 en=1 with eng_accept on the byte coinciding with eop -> fired=1, count[5] goes 0->1; a second packet on sid=5 loads the committed eng_state_out.
REQ-039 Packet sid=7 en=0 with accept -> fired=1 during RUN, cleared in COMMIT, count[7]=0, no state write.
REQ-040 sop during RUN and char_in_vld in IDLE -> ignored, proto_err=1 until reset.
REQ-041 COUNT_W=2: four matching packets on sid=1 -> count=0 without the macro, 3 with CANCID_CTX_SAT_COUNT_EN.
REQ-042 cnt_rd_sid=5 during the COMMIT cycle of sid 5 -> old value returned; the next cycle returns the new value.

Source files
------------

// File: rtl/cancid_pkg.sv
// Shared types and width defaults for the CANCID stream-context matcher.
package cancid_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_COMMIT = 2'd3
  } ctx_state_e;

  localparam int STATE_W_DEF = 11;
  localparam int COUNT_W_DEF = 16;

endpackage

// File: rtl/cancid_ctx_ram.sv
// Per-stream regex engine state store: one synchronous write port, one combinational read port.
module cancid_ctx_ram
  import cancid_pkg::*;
#(
  parameter int N_STREAMS = 64,
  parameter int SID_W     = $clog2(N_STREAMS),
  parameter int STATE_W   = STATE_W_DEF
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [SID_W-1:0]   i_waddr,
  input  logic [STATE_W-1:0] i_wdata,
  input  logic [SID_W-1:0]   i_raddr,
  output logic [STATE_W-1:0] o_rdata
);

  logic [STATE_W-1:0] r_mem [N_STREAMS];

  // NOTE: the storage array has no reset; stale entries are masked by the
  // ctx_valid bits in the top level, which keeps this mappable onto RAM.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cancid_ctx_matcher.sv
// Stream-context matcher: saves/restores regex engine state per stream and counts matching packets.
// Define CANCID_CTX_SAT_COUNT_EN to make the per-stream counters saturate instead of wrapping.
module cancid_ctx_matcher
  import cancid_pkg::*;
#(
  parameter int N_STREAMS = 64,
  parameter int SID_W     = $clog2(N_STREAMS),
  parameter int STATE_W   = STATE_W_DEF,
  parameter int COUNT_W   = COUNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sop,
  input  logic [SID_W-1:0]   stream_id,
  input  logic               enable,
  input  logic [7:0]         char_in,
  input  logic               char_in_vld,
  input  logic               eop,
  output logic [STATE_W-1:0] eng_state_in,
  output logic               eng_state_in_vld,
  output logic [7:0]         eng_char,
  output logic               eng_char_vld,
  input  logic [STATE_W-1:0] eng_state_out,
  input  logic               eng_accept,
  input  logic [SID_W-1:0]   cnt_rd_sid,
  output logic [COUNT_W-1:0] cnt_rd_data,
  output logic               fired,
  output logic               busy,
  output logic               proto_err
);

  ctx_state_e         r_state;
  logic [SID_W-1:0]   r_sid;
  logic               r_en;
  logic               r_fired;
  logic               r_proto_err;
  logic               r_state_in_vld;
  logic [STATE_W-1:0] r_state_in;
  logic [N_STREAMS-1:0] r_ctx_valid;
  logic [COUNT_W-1:0] r_count [N_STREAMS];
  logic [COUNT_W-1:0] r_cnt_rd;

  logic [STATE_W-1:0] w_mem_rd;
  logic               w_commit_we;
  logic               w_fired_final;
  logic               w_proto_viol;
  logic [COUNT_W-1:0] w_count_cur;
  logic [COUNT_W-1:0] w_count_nxt;

  cancid_ctx_ram #(
    .N_STREAMS (N_STREAMS),
    .SID_W     (SID_W),
    .STATE_W   (STATE_W)
  ) u_ctx_ram (
    .clk     (clk),
    .i_we    (w_commit_we),
    .i_waddr (r_sid),
    .i_wdata (eng_state_out),
    .i_raddr (stream_id),
    .o_rdata (w_mem_rd)
  );

  assign w_commit_we   = (r_state == ST_COMMIT) && r_en;
  // An accept for the byte that arrived with eop lands during COMMIT.
  assign w_fired_final = r_fired | eng_accept;
  assign w_count_cur   = r_count[r_sid];
  assign w_proto_viol  = (sop && (r_state != ST_IDLE)) ||
                         (eop && (r_state != ST_RUN)) ||
                         (char_in_vld && (r_state != ST_RUN));

`ifdef CANCID_CTX_SAT_COUNT_EN
  assign w_count_nxt = (&w_count_cur) ? w_count_cur : w_count_cur + COUNT_W'(w_fired_final);
`else
  assign w_count_nxt = w_count_cur + COUNT_W'(w_fired_final);
`endif

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_sid          <= '0;
      r_en           <= 1'b0;
      r_fired        <= 1'b0;
      r_proto_err    <= 1'b0;
      r_state_in_vld <= 1'b0;
      r_state_in     <= '0;
    end else begin
      r_state_in_vld <= 1'b0;
      if (w_proto_viol) r_proto_err <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (sop) begin
            r_state        <= ST_LOAD;
            r_sid          <= stream_id;
            r_en           <= enable;
            r_fired        <= 1'b0;
            r_state_in_vld <= 1'b1;
            r_state_in     <= r_ctx_valid[stream_id] ? w_mem_rd : '0;
          end
        end
        ST_LOAD: r_state <= ST_RUN;
        ST_RUN: begin
          if (eng_accept) r_fired <= 1'b1;
          if (eop) r_state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          r_state <= ST_IDLE;
          r_fired <= r_en ? w_fired_final : 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Counters and valid bits are flops so a reset clears every stream at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctx_valid <= '0;
      r_cnt_rd    <= '0;
      for (int i = 0; i < N_STREAMS; i++) r_count[i] <= '0;
    end else begin
      r_cnt_rd <= r_count[cnt_rd_sid];
      if (w_commit_we) begin
        r_ctx_valid[r_sid] <= 1'b1;
        r_count[r_sid]     <= w_count_nxt;
      end
    end
  end

  assign eng_state_in     = r_state_in;
  assign eng_state_in_vld = r_state_in_vld;
  assign eng_char         = char_in;
  assign eng_char_vld     = (r_state == ST_RUN) && char_in_vld;
  assign cnt_rd_data      = r_cnt_rd;
  assign fired            = r_fired;
  assign busy             = (r_state != ST_IDLE);
  assign proto_err        = r_proto_err;

endmodule

// File: tb/tb_cancid_ctx_matcher.sv
// Scoreboard bench for cancid_ctx_matcher; the bench also plays the external regex engine.
module tb_cancid_ctx_matcher;

  localparam int NS   = 8;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sop = 1'b0, enable = 1'b0, char_in_vld = 1'b0, eop = 1'b0;
  logic [2:0]  stream_id = '0, cnt_rd_sid = '0;
  logic [7:0]  char_in = '0;
  logic [10:0] eng_state_in, eng_state_out = '0;
  logic        eng_state_in_vld, eng_char_vld, eng_accept = 1'b0;
  logic [7:0]  eng_char;
  logic [CW-1:0] cnt_rd_data;
  logic        fired, busy, proto_err;

  cancid_ctx_matcher #(.N_STREAMS(NS), .COUNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .sop(sop), .stream_id(stream_id), .enable(enable),
    .char_in(char_in), .char_in_vld(char_in_vld), .eop(eop),
    .eng_state_in(eng_state_in), .eng_state_in_vld(eng_state_in_vld),
    .eng_char(eng_char), .eng_char_vld(eng_char_vld),
    .eng_state_out(eng_state_out), .eng_accept(eng_accept),
    .cnt_rd_sid(cnt_rd_sid), .cnt_rd_data(cnt_rd_data),
    .fired(fired), .busy(busy), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct { bit f_run; bit f_fin; bit proto; } fin_t;

  int n_cmp = 0, n_err = 0;
  int q_ld[$];
  int q_char[$];
  int q_cnt[$];
  fin_t q_fin[$];

  // Reference model of the per-stream context
  int  m_mem [NS];
  bit  m_valid [NS];
  int  m_cnt [NS];
  bit  exp_proto = 0;

  // Pending engine response for the next cycle
  bit  pend = 0, pend_acc = 0;
  int  pend_state = 0;
  bit  rd_req = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    if (pend) begin
      eng_state_out = 11'(pend_state);
      eng_accept    = pend_acc;
      pend          = 0;
    end else begin
      eng_accept = 1'b0;
    end
    sop = 1'b0; eop = 1'b0; char_in_vld = 1'b0; rd_req = 0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    pend = 0; eng_accept = 1'b0; eng_state_out = '0;
    sop = 1'b0; eop = 1'b0; char_in_vld = 1'b0; rd_req = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < NS; i++) begin m_valid[i] = 0; m_cnt[i] = 0; end
    exp_proto = 0;
  endtask

  function automatic int cnt_add(input int c, input bit f);
    int nv = c + int'(f);
`ifdef CANCID_CTX_SAT_COUNT_EN
    return (nv > CMAX) ? CMAX : nv;
`else
    return nv % (CMAX + 1);
`endif
  endfunction

  task automatic read_cnt(input int sid);
    cnt_rd_sid = 3'(sid);
    rd_req = 1;
    q_cnt.push_back(m_cnt[sid]);
  endtask

  // acc_mode: 0 none, 1 only the last byte, 2 random, 3 every byte
  task automatic send_packet(input int sid, input bit en, input int nbytes, input int acc_mode,
                             input bit eop_last, input bit bad_sop, input bit abort);
    int st, ld;
    bit f_run = 0, f_all = 0, a;
    logic [7:0] ch;
    fin_t fin;
    ld = m_valid[sid] ? m_mem[sid] : 0;
    tick(); sop = 1'b1; stream_id = 3'(sid); enable = en; q_ld.push_back(ld);
    tick(); pend = 1; pend_state = ld; pend_acc = 0; st = ld;
    if (bad_sop) begin
      tick(); sop = 1'b1; stream_id = 3'(sid ^ 1); enable = ~en; exp_proto = 1;
    end
    for (int i = 0; i < nbytes; i++) begin
      if ($urandom_range(3) == 0) tick();
      tick();
      ch = 8'($urandom);
      char_in_vld = 1'b1; char_in = ch; q_char.push_back(int'(ch));
      case (acc_mode)
        0: a = 0;
        1: a = (i == nbytes - 1);
        2: a = ($urandom_range(99) < 30);
        default: a = 1;
      endcase
      st = (st * 5 + int'(ch) + 1) % 2048;
      pend = 1; pend_state = st; pend_acc = a;
      f_all |= a;
      if (i == nbytes - 1 && eop_last) eop = 1'b1;
      else f_run |= a;
    end
    if (abort) begin
      tick();
      apply_reset();
      return;
    end
    if (!eop_last) begin tick(); eop = 1'b1; end
    tick(); read_cnt(sid);
    if (en) begin
      m_mem[sid] = st; m_valid[sid] = 1; m_cnt[sid] = cnt_add(m_cnt[sid], f_all);
    end
    fin.f_run = f_run; fin.f_fin = en ? f_all : 1'b0; fin.proto = exp_proto;
    q_fin.push_back(fin);
    tick(); read_cnt(sid);
  endtask

  // Monitor: compares whenever the DUT presents something
  initial begin : monitor
    bit busy_q = 0, fired_q = 0, rd_q = 0;
    fin_t f;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_q = 0; fired_q = 0; rd_q = 0;
      end else begin
        if (eng_state_in_vld) begin
          if (q_ld.size() == 0) check("unexpected_load", 32'(eng_state_in_vld), 0);
          else check("eng_state_in", 32'(eng_state_in), q_ld.pop_front());
        end
        if (eng_char_vld) begin
          if (q_char.size() == 0) check("unexpected_char", 32'(eng_char_vld), 0);
          else check("eng_char", 32'(eng_char), q_char.pop_front());
        end
        if (rd_q) begin
          if (q_cnt.size() == 0) check("unexpected_read", 32'(rd_q), 0);
          else check("cnt_rd_data", 32'(cnt_rd_data), q_cnt.pop_front());
        end
        if (busy_q && !busy) begin
          if (q_fin.size() == 0) check("unexpected_commit", 32'(busy_q), 0);
          else begin
            f = q_fin.pop_front();
            check("fired_in_commit", 32'(fired_q), 32'(f.f_run));
            check("fired_after", 32'(fired), 32'(f.f_fin));
            check("proto_err", 32'(proto_err), 32'(f.proto));
          end
        end
        rd_q = rd_req; busy_q = busy; fired_q = fired;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    apply_reset();
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_fired", 32'(fired), 0);
    check("rst_proto", 32'(proto_err), 0);
    check("rst_ld_vld", 32'(eng_state_in_vld), 0);
    check("rst_char_vld", 32'(eng_char_vld), 0);
    check("rst_cnt", 32'(cnt_rd_data), 0);

    // Fresh context loads zero; a second packet restores the committed state
    send_packet(3, 1, 4, 0, 0, 0, 0);
    send_packet(3, 1, 2, 0, 1, 0, 0);
    // Accept on the byte that coincides with eop
    send_packet(5, 1, 3, 1, 1, 0, 0);
    send_packet(5, 1, 3, 0, 0, 0, 0);
    // Disabled stream: fired visible in RUN, cleared afterwards, nothing stored
    send_packet(7, 0, 3, 3, 0, 0, 0);
    send_packet(7, 1, 2, 0, 1, 0, 0);

    for (int p = 0; p < 30; p++)
      send_packet(int'($urandom_range(NS - 1)), 1'($urandom_range(3) != 0),
                  int'($urandom_range(1, 6)), 2, 1'($urandom_range(1)), 0, 0);

    // Protocol violations: stray byte and eop in IDLE, sop during RUN
    tick(); char_in_vld = 1'b1; char_in = 8'h5a; exp_proto = 1;
    tick(); eop = 1'b1;
    send_packet(2, 1, 3, 2, 0, 1, 0);
    for (int p = 0; p < 4; p++)
      send_packet(int'($urandom_range(NS - 1)), 1, int'($urandom_range(1, 4)), 2,
                  1'($urandom_range(1)), 0, 0);

    // Reset mid-packet: no commit, all contexts and counters cleared
    send_packet(4, 1, 3, 3, 0, 0, 1);
    for (int i = 0; i < NS; i++) begin tick(); read_cnt(i); end
    send_packet(3, 1, 2, 0, 0, 0, 0);
    send_packet(4, 1, 2, 0, 0, 0, 0);

    // Counter width boundary: four matching packets on one stream
    for (int p = 0; p < 4; p++) send_packet(1, 1, 2, 3, 1'(p & 1), 0, 0);

    repeat (4) tick();
    @(negedge clk);
    check("proto_err_end", 32'(proto_err), 32'(exp_proto));
    check("q_ld_drained", q_ld.size(), 0);
    check("q_char_drained", q_char.size(), 0);
    check("q_cnt_drained", q_cnt.size(), 0);
    check("q_fin_drained", q_fin.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
